// File: rtl/down_timer_if.sv
// Load handshake between a producer and down_timer: start value plus periodic-mode flag.
interface down_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;

  modport master (
    output load_valid,
    output load_value,
    output auto_reload,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  auto_reload,
    output load_ready
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-cycle expiry pulse and optional auto-reload.
module down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  down_timer_if.slave      lif,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] period, period_d;
  logic             reload_r, reload_d;
  logic             done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      q        <= '0;
      period   <= '0;
      reload_r <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      q        <= q_d;
      period   <= period_d;
      reload_r <= reload_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    q_d      = q;
    period_d = period;
    reload_d = reload_r;
    done_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (lif.load_valid) begin
          period_d = lif.load_value;
          reload_d = lif.auto_reload;
          if (lif.load_value != '0) begin
            q_d     = lif.load_value;
            state_d = RUN;
          end else begin
            // zero load expires immediately and never reloads
            q_d    = '0;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          q_d     = '0;
          state_d = IDLE;
        end else if (enable) begin
          if (q > WIDTH'(1)) begin
            q_d = q - WIDTH'(1);
          end else if (q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (reload_r) begin
              q_d = period;
            end else begin
              q_d     = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state == RUN);
  assign lif.load_ready = (state == IDLE);

endmodule
